// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared state encoding and line-level constants for the UART TX.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_parity_calc.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_parity_calc
// Brief  : Combinational even/odd parity over one payload word.
// Rev    : 1.0
// ============================================================================
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    logic w_xor;

    assign w_xor    = ^data_i;
    assign parity_o = (par_typ_i == PAR_ODD) ? ~w_xor : w_xor;

endmodule : uart_tx_parity_calc
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : One-bit-per-clock UART transmitter: start, LSB-first data,
//          optional parity, stop. All outputs registered.
// Rev    : 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_typ,
    input  logic                  par_en,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_bit_q;
    logic                  par_en_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  parity_d;

    // Parity is taken from the word being accepted, so it matches the latched copy.
    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (p_data),
        .par_typ_i (par_typ),
        .parity_o  (parity_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                    if (data_valid) begin
                        data_q    <= p_data;
                        par_en_q  <= par_en;
                        par_bit_q <= parity_d;
                        state_q   <= START;
                        tx_q      <= START_BIT;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    // The held word is shifted out so bit 0 is always the next to send.
                    state_q <= DATA;
                    cnt_q   <= '0;
                    tx_q    <= data_q[0];
                    data_q  <= data_q >> 1;
                end
                DATA: begin
                    if (cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= STOP_BIT;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        tx_q   <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= STOP_BIT;
                end
                STOP: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx
// Brief  : Self-checking bench for uart_tx against a frame-list reference.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         par_typ;
    logic         par_en;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         tx_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int frame   = 0;

    uart_tx #(
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .par_typ    (par_typ),
        .par_en     (par_en),
        .p_data     (p_data),
        .data_valid (data_valid),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
    task automatic run_frame(input logic [W-1:0] d, input logic typ, input logic en,
                             input bit scramble);
        bit q[$];
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (en) q.push_back((($countones(d) % 2) == 1) ^ typ);
        q.push_back(1'b1);

        p_data = d; par_typ = typ; par_en = en; data_valid = 1'b1;
        foreach (q[i]) begin
            @(negedge clk);
            check_eq($sformatf("f%0d tx[%0d]", frame, i), {31'd0, tx_out}, {31'd0, q[i]});
            check_eq($sformatf("f%0d busy[%0d]", frame, i), {31'd0, busy}, 32'd1);
            if (scramble) begin
                p_data     = W'($urandom);
                par_typ    = 1'($urandom_range(0, 1));
                par_en     = 1'($urandom_range(0, 1));
                data_valid = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        check_eq($sformatf("f%0d idle tx", frame), {31'd0, tx_out}, 32'd1);
        check_eq($sformatf("f%0d idle busy", frame), {31'd0, busy}, 32'd0);
        data_valid = 1'b0;
        frame++;
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; par_typ = 1'b0; par_en = 1'b0; p_data = '0;
        @(negedge clk);
        check_eq("reset tx", {31'd0, tx_out}, 32'd1);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post-reset tx", {31'd0, tx_out}, 32'd1);
        check_eq("post-reset busy", {31'd0, busy}, 32'd0);

        // Directed frames, chained back-to-back with one idle cycle between.
        run_frame(8'b10101001, 1'b0, 1'b1, 1'b0);
        run_frame(8'b10111100, 1'b0, 1'b1, 1'b0);
        run_frame(8'b10101001, 1'b1, 1'b1, 1'b0);
        run_frame(8'b10111100, 1'b1, 1'b1, 1'b0);
        run_frame(8'b10101001, 1'b0, 1'b0, 1'b0);
        run_frame(8'h00, 1'b1, 1'b1, 1'b1);
        run_frame(8'hFF, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of the data bits aborts the frame.
        p_data = 8'h5A; par_typ = 1'b0; par_en = 1'b1; data_valid = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("pre-abort busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; data_valid = 1'b0;
        @(negedge clk);
        check_eq("abort tx", {31'd0, tx_out}, 32'd1);
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort idle tx", {31'd0, tx_out}, 32'd1);
        check_eq("abort idle busy", {31'd0, busy}, 32'd0);

        // Random frames with inputs churned while the frame is in flight.
        for (int k = 0; k < 40; k++) begin
            run_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check_eq("gap busy", {31'd0, busy}, 32'd0);
                    check_eq("gap tx", {31'd0, tx_out}, 32'd1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
